gearbox_frame_ctrl: RTL and testbench

Frame sequencer in front of the 24-to-32 gearbox. It accepts a frame command with a pixel count and paces 24-bit pixels from the pixel source into the gearbox as data_en, data_in_last and data_in_rgb, honouring gearbox backpressure. It then monitors the gearbox's 32-bit output to check the frame's word count and detect a missing end-of-frame. It reports done, error and tail byte-keep to the system controller.

---
 rtl/gearbox_frame_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_gearbox_frame_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_frame_ctrl.sv
// gearbox_frame_ctrl
//
// Frame sequencer in front of the 24-to-32 gearbox. A frame command carries a
// pixel count. The block paces that many 24-bit pixels from the pixel source
// into the gearbox, one cycle after each accept, and honours gearbox
// backpressure. It then watches the gearbox's 32-bit output to check the
// frame's word count and to catch a missing or early end-of-frame.
//
// Ports:
//   clk_200m, reset_n          system clock, asynchronous active-low reset
//   cfg_start, cfg_len         frame start pulse and pixel count (IDLE only)
//   src_valid, src_data        pixel source, {R,G,B}
//   src_ready                  combinational accept; pixel taken when src_valid also high
//   gb_full                    gearbox cannot take a pixel this cycle
//   data_en, data_in_last      registered pixel strobe and end-of-frame marker to gearbox
//   data_in_rgb                registered pixel to gearbox
//   gb_out_valid, gb_out_last  gearbox 32-bit output monitor
//   busy                       frame in progress
//   done                       one-cycle end-of-frame pulse
//   err_len, err_timeout       status, valid with done
//   exp_words, tail_keep       expected output words and last-word byte keep,
//                              held until the next accepted start

module gearbox_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk_200m,
  input  logic             reset_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             src_valid,
  input  logic [23:0]      src_data,
  output logic             src_ready,
  input  logic             gb_full,
  output logic             data_en,
  output logic             data_in_last,
  output logic [23:0]      data_in_rgb,
  input  logic             gb_out_valid,
  input  logic             gb_out_last,
  output logic             busy,
  output logic             done,
  output logic             err_len,
  output logic             err_timeout,
  output logic [15:0]      exp_words,
  output logic [3:0]       tail_keep
);

  // 3*len needs two extra bits; +3 for the round-up still fits because
  // 3*(2^LEN_W-1)+3 < 2^(LEN_W+2).
  localparam int unsigned BytesW = LEN_W + 2;
  // The drain counter only has to reach TIMEOUT_CYC-1.
  localparam int unsigned TmoW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [TmoW-1:0]  TmoOne  = TmoW'(1);
  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
  localparam logic [15:0]      CntMax  = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]      out_cnt_q, out_cnt_d;
  logic             last_seen_q, last_seen_d;
  logic             early_q, early_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [15:0]      exp_words_q, exp_words_d;
  logic [3:0]       tail_keep_q, tail_keep_d;
  logic             data_en_q, data_en_d;
  logic             data_last_q, data_last_d;
  logic [23:0]      data_rgb_q, data_rgb_d;
  logic             done_q, done_d;
  logic             err_len_q, err_len_d;
  logic             err_timeout_q, err_timeout_d;

  logic [BytesW-1:0] cfg_bytes;
  logic [BytesW-1:0] cfg_bytes_rnd;
  logic [3:0]        cfg_keep;
  logic              sent_all;
  logic              accept;
  logic              last_pix;
  logic              out_word;
  logic              last_hit;
  logic [15:0]       out_cnt_inc;

  // Frame geometry from the requested length: 3*len = 2*len + len.
  assign cfg_bytes     = {1'b0, cfg_len, 1'b0} + {2'b00, cfg_len};
  assign cfg_bytes_rnd = cfg_bytes + BytesW'(3);

  always_comb begin
    cfg_keep = 4'b1111;
    unique case (cfg_bytes[1:0])
      2'd0: cfg_keep = 4'b1111;
      2'd1: cfg_keep = 4'b0001;
      2'd2: cfg_keep = 4'b0011;
      2'd3: cfg_keep = 4'b0111;
      default: cfg_keep = 4'b1111;
    endcase
  end

  // Source handshake. Only RUN can accept, and only while the gearbox has room.
  assign sent_all  = (pix_cnt_q == len_q);
  assign src_ready = (state_q == StRun) && !gb_full && !sent_all;
  assign accept    = src_valid && src_ready;
  assign last_pix  = (pix_cnt_q == (len_q - LenOne));

  // Output monitor is live only while a frame is in flight (RUN, or DRAIN up
  // to and including the cycle that moves to DONE).
  assign out_word    = gb_out_valid && ((state_q == StRun) || (state_q == StDrain));
  assign last_hit    = out_word && gb_out_last;
  assign out_cnt_inc = (out_cnt_q == CntMax) ? out_cnt_q : (out_cnt_q + 16'd1);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    pix_cnt_d     = pix_cnt_q;
    out_cnt_d     = out_word ? out_cnt_inc : out_cnt_q;
    last_seen_d   = last_seen_q | last_hit;
    early_d       = early_q | (last_hit & (state_q == StRun));
    tmo_cnt_d     = tmo_cnt_q;
    exp_words_d   = exp_words_q;
    tail_keep_d   = tail_keep_q;
    data_en_d     = accept;
    data_last_d   = accept & last_pix;
    data_rgb_d    = accept ? src_data : data_rgb_q;
    done_d        = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A zero-length command carries no frame and is dropped.
        if (cfg_start && (cfg_len != '0)) begin
          state_d     = StRun;
          len_d       = cfg_len;
          pix_cnt_d   = '0;
          out_cnt_d   = '0;
          last_seen_d = 1'b0;
          early_d     = 1'b0;
          tmo_cnt_d   = '0;
          exp_words_d = 16'(cfg_bytes_rnd >> 2);
          tail_keep_d = cfg_keep;
        end
      end

      StRun: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + LenOne;
          if (last_pix) begin
            state_d   = StDrain;
            tmo_cnt_d = '0;
          end
        end
      end

      StDrain: begin
        tmo_cnt_d = tmo_cnt_q + TmoOne;
        // out_cnt_d already includes a word arriving on this terminating cycle.
        if (last_seen_q || last_hit) begin
          state_d   = StDone;
          done_d    = 1'b1;
          err_len_d = early_q || (out_cnt_d != exp_words_q);
        end else if (tmo_cnt_q == TmoLast) begin
          state_d       = StDone;
          done_d        = 1'b1;
          err_len_d     = early_q || (out_cnt_d != exp_words_q);
          err_timeout_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      pix_cnt_q     <= '0;
      out_cnt_q     <= '0;
      last_seen_q   <= 1'b0;
      early_q       <= 1'b0;
      tmo_cnt_q     <= '0;
      exp_words_q   <= '0;
      tail_keep_q   <= '0;
      data_en_q     <= 1'b0;
      data_last_q   <= 1'b0;
      data_rgb_q    <= '0;
      done_q        <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      pix_cnt_q     <= pix_cnt_d;
      out_cnt_q     <= out_cnt_d;
      last_seen_q   <= last_seen_d;
      early_q       <= early_d;
      tmo_cnt_q     <= tmo_cnt_d;
      exp_words_q   <= exp_words_d;
      tail_keep_q   <= tail_keep_d;
      data_en_q     <= data_en_d;
      data_last_q   <= data_last_d;
      data_rgb_q    <= data_rgb_d;
      done_q        <= done_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_timeout_q;
  assign data_en      = data_en_q;
  assign data_in_last = data_last_q;
  assign data_in_rgb  = data_rgb_q;
  assign exp_words    = exp_words_q;
  assign tail_keep    = tail_keep_q;

endmodule

// File: tb/tb_gearbox_frame_ctrl.sv
// Testbench for gearbox_frame_ctrl: a table of directed frames, randomized
// frames checked against a behavioural model, and hand-written sequences for
// reset, ignored commands and large-length arithmetic.

module tb_gearbox_frame_ctrl;

  localparam int unsigned TMO = 16;

  logic        clk_200m = 1'b0;
  logic        reset_n;
  logic        cfg_start;
  logic [15:0] cfg_len;
  logic        src_valid;
  logic [23:0] src_data;
  logic        src_ready;
  logic        gb_full;
  logic        data_en;
  logic        data_in_last;
  logic [23:0] data_in_rgb;
  logic        gb_out_valid;
  logic        gb_out_last;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        err_timeout;
  logic [15:0] exp_words;
  logic [3:0]  tail_keep;

  int n_checks = 0;
  int n_pass   = 0;

  gearbox_frame_ctrl #(
    .TIMEOUT_CYC(TMO),
    .LEN_W      (16)
  ) dut (
    .clk_200m    (clk_200m),
    .reset_n     (reset_n),
    .cfg_start   (cfg_start),
    .cfg_len     (cfg_len),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .gb_full     (gb_full),
    .data_en     (data_en),
    .data_in_last(data_in_last),
    .data_in_rgb (data_in_rgb),
    .gb_out_valid(gb_out_valid),
    .gb_out_last (gb_out_last),
    .busy        (busy),
    .done        (done),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .exp_words   (exp_words),
    .tail_keep   (tail_keep)
  );

  always #5 clk_200m = ~clk_200m;

  typedef struct {
    int unsigned len;
    int unsigned full_mode;   // 0 never full, 1 every other cycle, 2 random
    int unsigned valid_mode;  // 0 always valid, 1 patterned gaps, 2 random
    int unsigned n_words;     // gearbox output words to emit
    bit          give_last;   // last on the final emitted word
    bit          early;       // emit words from the first RUN cycle
    int unsigned exp_words;
    int unsigned exp_keep;
    bit          exp_err_len;
    bit          exp_err_tmo;
  } frame_t;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Reference: expected geometry and status straight from the frame rules.
  function automatic frame_t model(input frame_t f);
    frame_t      r;
    int unsigned bytes;
    int unsigned counted;
    r           = f;
    bytes       = 3 * f.len;
    r.exp_words = (bytes + 3) / 4;
    case (bytes % 4)
      0:       r.exp_keep = 4'b1111;
      1:       r.exp_keep = 4'b0001;
      2:       r.exp_keep = 4'b0011;
      default: r.exp_keep = 4'b0111;
    endcase
    if (f.early) begin
      counted       = f.n_words;
      r.exp_err_tmo = 1'b0;
    end else if (f.give_last && f.n_words >= 1 && f.n_words <= TMO) begin
      counted       = f.n_words;
      r.exp_err_tmo = 1'b0;
    end else begin
      counted       = (f.n_words < TMO) ? f.n_words : TMO;
      r.exp_err_tmo = 1'b1;
    end
    r.exp_err_len = f.early || (counted != r.exp_words);
    return r;
  endfunction

  task automatic run_frame(input frame_t f, input string tag);
    int unsigned sent      = 0;
    int          drain_at  = -1;
    int          done_at   = -1;
    bit          in_run    = 1'b1;
    bit          prev_acc  = 1'b0;
    bit          prev_last = 1'b0;
    logic [23:0] prev_pix  = '0;
    bit          exp_ready;
    bit          acc;
    bit          finished  = 1'b0;

    cfg_start = 1'b1;
    cfg_len   = 16'(f.len);
    @(posedge clk_200m); #1;
    cfg_start = 1'b0;
    cfg_len   = '0;

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      case (f.full_mode)
        0:       gb_full = 1'b0;
        1:       gb_full = (cyc % 2) == 1;
        default: gb_full = ($urandom_range(0, 9) < 3);
      endcase
      case (f.valid_mode)
        0:       src_valid = 1'b1;
        1:       src_valid = (cyc % 3) != 2;
        default: src_valid = ($urandom_range(0, 9) < 7);
      endcase
      src_data = (f.valid_mode == 2) ? 24'($urandom) : (24'h302010 + 24'(sent) * 24'h010101);

      gb_out_valid = 1'b0;
      gb_out_last  = 1'b0;
      if (f.early) begin
        if (cyc < int'(f.n_words)) begin
          gb_out_valid = 1'b1;
          gb_out_last  = (cyc == int'(f.n_words) - 1);
        end
      end else if (drain_at >= 0 && (cyc - drain_at) < int'(f.n_words)) begin
        gb_out_valid = 1'b1;
        gb_out_last  = f.give_last && ((cyc - drain_at) == int'(f.n_words) - 1);
      end

      @(negedge clk_200m);
      exp_ready = in_run && !gb_full;
      if (cyc == 0) begin
        check({tag, " exp_words"}, exp_words, f.exp_words);
        check({tag, " tail_keep"}, tail_keep, f.exp_keep);
      end
      check({tag, " src_ready"}, src_ready, exp_ready);
      check({tag, " data_en"}, data_en, prev_acc);
      if (prev_acc) begin
        check({tag, " data_in_rgb"}, data_in_rgb, prev_pix);
        check({tag, " data_in_last"}, data_in_last, prev_last);
      end
      check({tag, " done"}, done, (cyc == done_at));
      if (cyc == done_at) begin
        check({tag, " err_len"}, err_len, f.exp_err_len);
        check({tag, " err_timeout"}, err_timeout, f.exp_err_tmo);
        check({tag, " held exp_words"}, exp_words, f.exp_words);
        check({tag, " held tail_keep"}, tail_keep, f.exp_keep);
        finished = 1'b1;
      end else begin
        check({tag, " busy"}, busy, 1'b1);
      end

      acc       = src_valid && exp_ready;
      prev_last = acc && (sent == f.len - 1);
      prev_acc  = acc;
      prev_pix  = src_data;
      if (acc) begin
        sent++;
        if (sent == f.len) begin
          in_run   = 1'b0;
          drain_at = cyc + 1;
          if (f.early) done_at = drain_at + 1;
          else if (f.give_last && f.n_words >= 1 && f.n_words <= TMO)
            done_at = drain_at + int'(f.n_words);
          else done_at = drain_at + int'(TMO);
        end
      end
      @(posedge clk_200m); #1;
    end

    src_valid    = 1'b0;
    gb_full      = 1'b0;
    gb_out_valid = 1'b0;
    gb_out_last  = 1'b0;
    if (!finished) begin
      n_checks++;
      $display("FAIL %s done_wait: no done within 400 cycles, expected one", tag);
    end
    @(negedge clk_200m);
    check({tag, " busy after done"}, busy, 1'b0);
    check({tag, " done after done"}, done, 1'b0);
    @(posedge clk_200m); #1;
  endtask

  frame_t tbl [10];
  frame_t rf;

  initial begin
    // len, full, valid, n_words, last, early, exp_words, keep, err_len, err_tmo
    tbl[0] = '{8,  0, 0, 6, 1, 0, 6, 4'hF, 0, 0};
    tbl[1] = '{9,  0, 0, 7, 1, 0, 7, 4'h7, 0, 0};
    tbl[2] = '{10, 0, 0, 8, 1, 0, 8, 4'h3, 0, 0};
    tbl[3] = '{11, 0, 0, 9, 1, 0, 9, 4'h1, 0, 0};
    tbl[4] = '{8,  1, 1, 6, 1, 0, 6, 4'hF, 0, 0};
    tbl[5] = '{8,  0, 0, 5, 1, 0, 6, 4'hF, 1, 0};
    tbl[6] = '{8,  0, 0, 6, 1, 1, 6, 4'hF, 1, 0};
    tbl[7] = '{4,  0, 0, 0, 0, 0, 3, 4'hF, 1, 1};
    tbl[8] = '{1,  0, 0, 1, 1, 0, 1, 4'h7, 0, 0};
    tbl[9] = '{3,  2, 2, 3, 1, 0, 3, 4'h1, 0, 0};

    reset_n      = 1'b0;
    cfg_start    = 1'b0;
    cfg_len      = '0;
    src_valid    = 1'b0;
    src_data     = '0;
    gb_full      = 1'b0;
    gb_out_valid = 1'b0;
    gb_out_last  = 1'b0;

    repeat (3) @(posedge clk_200m);
    @(negedge clk_200m);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset data_en", data_en, 1'b0);
    check("reset data_in_last", data_in_last, 1'b0);
    check("reset data_in_rgb", data_in_rgb, 24'h0);
    check("reset exp_words", exp_words, 16'h0);
    check("reset tail_keep", tail_keep, 4'h0);
    check("reset err_len", err_len, 1'b0);
    check("reset err_timeout", err_timeout, 1'b0);
    @(posedge clk_200m); #1;
    reset_n = 1'b1;

    // Zero-length start and gearbox activity in IDLE are both ignored.
    cfg_start    = 1'b1;
    cfg_len      = 16'd0;
    src_valid    = 1'b1;
    gb_out_valid = 1'b1;
    gb_out_last  = 1'b1;
    @(negedge clk_200m);
    check("idle src_ready", src_ready, 1'b0);
    @(posedge clk_200m); #1;
    cfg_start    = 1'b0;
    gb_out_valid = 1'b0;
    gb_out_last  = 1'b0;
    @(negedge clk_200m);
    check("len0 busy", busy, 1'b0);
    check("len0 data_en", data_en, 1'b0);
    src_valid = 1'b0;
    @(posedge clk_200m); #1;

    for (int i = 0; i < 10; i++) run_frame(tbl[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 20; i++) begin
      rf.len        = $urandom_range(1, 20);
      rf.full_mode  = 2;
      rf.valid_mode = 2;
      rf.early      = 1'b0;
      rf.give_last  = ($urandom_range(0, 3) != 0);
      rf            = model(rf);
      rf.n_words    = rf.exp_words + $urandom_range(0, 2) - 1;
      rf            = model(rf);
      run_frame(rf, $sformatf("rnd%0d", i));
    end

    // Max length arithmetic, start ignored while busy, async reset mid-RUN.
    cfg_start = 1'b1;
    cfg_len   = 16'hFFFF;
    @(posedge clk_200m); #1;
    cfg_start = 1'b0;
    src_valid = 1'b1;
    src_data  = 24'hABCDEF;
    @(negedge clk_200m);
    check("max exp_words", exp_words, 16'hC000);
    check("max tail_keep", tail_keep, 4'h1);
    check("max busy", busy, 1'b1);
    check("max src_ready", src_ready, 1'b1);
    @(posedge clk_200m); #1;
    cfg_start = 1'b1;
    cfg_len   = 16'd4;
    src_data  = 24'h123456;
    @(negedge clk_200m);
    check("max data_en", data_en, 1'b1);
    check("max data_in_rgb", data_in_rgb, 24'hABCDEF);
    check("max data_in_last", data_in_last, 1'b0);
    @(posedge clk_200m); #1;
    cfg_start = 1'b0;
    @(negedge clk_200m);
    check("busy start ignored exp_words", exp_words, 16'hC000);
    check("busy start ignored tail_keep", tail_keep, 4'h1);
    check("second pixel rgb", data_in_rgb, 24'h123456);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset data_en", data_en, 1'b0);
    check("async reset done", done, 1'b0);
    check("async reset data_in_rgb", data_in_rgb, 24'h0);
    check("async reset exp_words", exp_words, 16'h0);
    check("async reset src_ready", src_ready, 1'b0);
    src_valid = 1'b0;
    @(posedge clk_200m); #1;
    reset_n = 1'b1;
    @(negedge clk_200m);
    check("post reset busy", busy, 1'b0);
    check("post reset data_en", data_en, 1'b0);
    check("post reset done", done, 1'b0);

    // A normal frame still runs after the mid-frame reset.
    run_frame(tbl[0], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
